// File: rtl/lab05_pkg.sv
// Shared constants, state type and width helper for the slow-domain averager.
package lab05_pkg;

    localparam int DATA_W_DEF = 12;

    // Two bits wide so that unused encodings exist and can be recovered from.
    typedef enum logic [1:0] {
        ST_DISCARD = 2'b00,
        ST_ACCUM   = 2'b01
    } avg_state_t;

    // The accumulator must hold a full block of full-scale samples.
    function automatic int acc_width(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

endpackage

// File: rtl/slow_sample_averager_minmax.sv
// Running minimum/maximum of the samples accepted in the current block.
// min_with/max_with include the sample on the input this cycle, so the
// parent can publish them on the edge that accepts the final sample.
module minmax_tracker #(
    parameter int DATA_W = 12
) (
    input  logic              SLOW_clk,
    input  logic              reset_n,
    input  logic              init,
    input  logic              update,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] min_with,
    output logic [DATA_W-1:0] max_with
);

    logic [DATA_W-1:0] run_min;
    logic [DATA_W-1:0] run_max;

    // Candidate extremes including the sample presented this cycle.
    always_comb begin
        min_with = (sample < run_min) ? sample : run_min;
        max_with = (sample > run_max) ? sample : run_max;
    end

    // init wins over update so a completing block restarts cleanly.
    always_ff @(posedge SLOW_clk or negedge reset_n) begin
        if (!reset_n) begin
            run_min <= '1;
            run_max <= '0;
        end else if (init) begin
            run_min <= '1;
            run_max <= '0;
        end else if (update) begin
            run_min <= min_with;
            run_max <= max_with;
        end
    end

endmodule

// File: rtl/slow_sample_averager.sv
// Block averager for the synchronized 12-bit word: drops the first DISCARD
// strobes while the synchronizer fills, then publishes floor average, min
// and max once per 2^LOG2_N accepted samples with a one-cycle strobe.
module slow_sample_averager
    import lab05_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LOG2_N  = 4,
    parameter int DISCARD = 2
) (
    input  logic              SLOW_clk,
    input  logic              reset_n,
    input  logic              sample_en,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] avg_out,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] max_out,
    output logic              avg_valid,
    output logic [LOG2_N-1:0] sample_cnt
);

    localparam int         ACC_W    = acc_width(DATA_W, LOG2_N);
    localparam int         DC_W     = (DISCARD > 1) ? $clog2(DISCARD) : 1;
    localparam avg_state_t START_ST = (DISCARD == 0) ? ST_ACCUM : ST_DISCARD;

    avg_state_t        state;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [DC_W-1:0]   disc_cnt;
    logic              take;
    logic              last;
    logic [DATA_W-1:0] min_with;
    logic [DATA_W-1:0] max_with;

    // Accepted sample this cycle, and whether it closes the block.
    always_comb begin
        take    = !clear && sample_en && (state == ST_ACCUM);
        last    = take && (sample_cnt == '1);
        acc_sum = acc + ACC_W'(data_in);
    end

    minmax_tracker #(.DATA_W(DATA_W)) u_minmax (
        .SLOW_clk (SLOW_clk),
        .reset_n  (reset_n),
        .init     (clear || last),
        .update   (take),
        .sample   (data_in),
        .min_with (min_with),
        .max_with (max_with)
    );

    // Discard/accumulate FSM with counters, accumulator and published results.
    always_ff @(posedge SLOW_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= START_ST;
            acc        <= '0;
            disc_cnt   <= '0;
            sample_cnt <= '0;
            avg_out    <= '0;
            min_out    <= '0;
            max_out    <= '0;
            avg_valid  <= 1'b0;
        end else if (clear) begin
            // Published values are kept; only the block in flight is dropped.
            state      <= START_ST;
            acc        <= '0;
            disc_cnt   <= '0;
            sample_cnt <= '0;
            avg_valid  <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            case (state)
                ST_DISCARD: begin
                    if (DISCARD == 0) begin
                        state <= ST_ACCUM;
                    end else if (sample_en) begin
                        if (disc_cnt == DC_W'(DISCARD - 1)) begin
                            state    <= ST_ACCUM;
                            disc_cnt <= '0;
                        end else begin
                            disc_cnt <= disc_cnt + 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (sample_en) begin
                        if (sample_cnt == '1) begin
                            avg_out    <= DATA_W'(acc_sum >> LOG2_N);
                            min_out    <= min_with;
                            max_out    <= max_with;
                            avg_valid  <= 1'b1;
                            acc        <= '0;
                            sample_cnt <= '0;
                        end else begin
                            acc        <= acc_sum;
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_DISCARD;
                    acc        <= '0;
                    disc_cnt   <= '0;
                    sample_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slow_sample_averager.sv
// Randomized and directed check of slow_sample_averager against a
// queue-based block model (LOG2_N=2, DISCARD=2).
module tb_slow_sample_averager;

    localparam int DW  = 12;
    localparam int L2N = 2;
    localparam int NB  = 1 << L2N;
    localparam int DSC = 2;

    logic          SLOW_clk;
    logic          reset_n;
    logic          sample_en;
    logic          clear;
    logic [DW-1:0] data_in;
    logic [DW-1:0] avg_out;
    logic [DW-1:0] min_out;
    logic [DW-1:0] max_out;
    logic          avg_valid;
    logic [L2N-1:0] sample_cnt;

    int checks = 0;
    int errors = 0;

    // model state
    int q[$];
    int disc_left;
    int m_avg, m_min, m_max, m_vld;

    slow_sample_averager #(.DATA_W(DW), .LOG2_N(L2N), .DISCARD(DSC)) dut (
        .SLOW_clk   (SLOW_clk),
        .reset_n    (reset_n),
        .sample_en  (sample_en),
        .clear      (clear),
        .data_in    (data_in),
        .avg_out    (avg_out),
        .min_out    (min_out),
        .max_out    (max_out),
        .avg_valid  (avg_valid),
        .sample_cnt (sample_cnt)
    );

    initial SLOW_clk = 1'b0;
    always #5 SLOW_clk = ~SLOW_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".avg"}, int'(avg_out), m_avg);
        chk({tag, ".min"}, int'(min_out), m_min);
        chk({tag, ".max"}, int'(max_out), m_max);
        chk({tag, ".vld"}, int'(avg_valid), m_vld);
        chk({tag, ".cnt"}, int'(sample_cnt), q.size());
    endtask

    task automatic model_reset();
        q.delete();
        disc_left = DSC;
        m_avg = 0; m_min = 0; m_max = 0; m_vld = 0;
    endtask

    // Block-level reference: count off discards, collect a block, summarize it.
    task automatic model_step(input bit en, input bit clr, input int d);
        int s, mn, mx;
        m_vld = 0;
        if (clr) begin
            q.delete();
            disc_left = DSC;
        end else if (en) begin
            if (disc_left > 0) disc_left--;
            else begin
                q.push_back(d);
                if (q.size() == NB) begin
                    s = 0; mn = (1 << DW) - 1; mx = 0;
                    foreach (q[i]) begin
                        s += q[i];
                        if (q[i] < mn) mn = q[i];
                        if (q[i] > mx) mx = q[i];
                    end
                    m_avg = s / NB;
                    m_min = mn;
                    m_max = mx;
                    m_vld = 1;
                    q.delete();
                end
            end
        end
    endtask

    task automatic cyc(input string tag, input bit en, input bit clr, input int d);
        sample_en = en;
        clear     = clr;
        data_in   = DW'(d);
        @(posedge SLOW_clk);
        #1;
        model_step(en, clr, d);
        chk_all(tag);
    endtask

    task automatic idle(input string tag, input int n, input int d);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, d);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sample_en = 1'b0; clear = 1'b0; data_in = '0;
        @(negedge SLOW_clk);
        model_reset();
        chk_all("reset");
        reset_n = 1'b1;
        @(posedge SLOW_clk);
        #1;
    endtask

    initial begin
        int gap_avg;
        model_reset();
        do_reset();

        // Discards of full scale must not leak into the first block.
        cyc("disc", 1, 0, 12'hFFF);
        cyc("disc", 1, 0, 12'hFFF);
        cyc("blk1", 1, 0, 100);
        cyc("blk1", 1, 0, 200);
        cyc("blk1", 1, 0, 300);
        cyc("blk1", 1, 0, 400);
        chk("blk1.avg250", int'(avg_out), 250);
        idle("post1", 2, 0);

        // Full scale block.
        for (int i = 0; i < NB; i++) cyc("full", 1, 0, 12'hFFF);
        chk("full.avg", int'(avg_out), 12'hFFF);
        idle("post2", 1, 0);

        // Truncation, then a back-to-back zero block.
        cyc("trunc", 1, 0, 1); cyc("trunc", 1, 0, 1);
        cyc("trunc", 1, 0, 1); cyc("trunc", 1, 0, 2);
        chk("trunc.avg", int'(avg_out), 1);
        for (int i = 0; i < NB; i++) cyc("zero", 1, 0, 0);
        chk("zero.avg", int'(avg_out), 0);

        // Sparse samples with junk on data_in between strobes.
        foreach (q[i]) ;
        for (int i = 0; i < NB; i++) begin
            cyc("gap", 1, 0, 100 * (i + 1));
            idle("gapidle", 3, 12'hABC);
        end
        gap_avg = int'(avg_out);
        chk("gap.avg250", gap_avg, 250);
        chk("gap.max400", int'(max_out), 400);

        // Clear mid-block, coincident with a sample.
        cyc("clr", 1, 0, 10); cyc("clr", 1, 0, 20);
        cyc("clr", 1, 1, 30);
        chk("clr.avgkept", int'(avg_out), 250);
        cyc("clrdisc", 1, 0, 12'hFFF); cyc("clrdisc", 1, 0, 12'hFFF);
        cyc("clrblk", 1, 0, 8); cyc("clrblk", 1, 0, 4);
        cyc("clrblk", 1, 0, 6); cyc("clrblk", 1, 0, 2);
        chk("clrblk.avg", int'(avg_out), 5);

        // Clear on the completion cycle drops the block.
        for (int i = 0; i < NB - 1; i++) cyc("clrlast", 1, 0, 900);
        cyc("clrlast", 1, 1, 900);
        idle("clrlast", 1, 0);

        // Asynchronous reset between edges, mid-block.
        cyc("arst", 1, 0, 7); cyc("arst", 1, 0, 7);
        for (int i = 0; i < NB; i++) cyc("arst", 1, 0, 7);
        cyc("arst", 1, 0, 7);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        chk_all("arst.async");
        @(negedge SLOW_clk);
        reset_n = 1'b1;
        cyc("arst.disc", 1, 0, 12'hFFF); cyc("arst.disc", 1, 0, 12'hFFF);
        for (int i = 0; i < NB; i++) cyc("arst.blk", 1, 0, 40 + i);

        // Random traffic with occasional clears.
        for (int i = 0; i < 600; i++) begin
            cyc("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
                int'($urandom_range(0, (1 << DW) - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop guard in case stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got stall expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/slow_sample_averager.md
Name: slow_sample_averager

Overview:
- Slow-domain consumer of the 12-bit word produced by the fast-to-slow synchronizer.
- Discards the first samples after reset or clear, because the synchronizer pipeline is still filling.
- Accumulates fixed-size blocks of 2^LOG2_N samples and publishes, once per block, the floor average plus the block minimum and maximum, with a one-cycle valid strobe.
- Feeds the display/readout logic.

Parameters:
- DATA_W, 12: sample width, matches the synchronizer output.
- LOG2_N, 4: log2 of samples per block (block size 16).
- DISCARD, 2: sample_en pulses ignored after reset/clear; 0 means start directly in ACCUM.

Ports:
- SLOW_clk  input  1  slow-domain clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sample_en  input  1  sample strobe; data_in is consumed only on cycles where this is 1.
- clear  input  1  synchronous restart of the current block.
- data_in  input  DATA_W  synchronized sample (synchronizer sync_data_out).
- avg_out  output  DATA_W  floor average of the last completed block.
- min_out  output  DATA_W  minimum sample of the last completed block.
- max_out  output  DATA_W  maximum sample of the last completed block.
- avg_valid  output  1  one-cycle pulse when avg_out/min_out/max_out update.
- sample_cnt  output  LOG2_N  samples accepted so far in the current block.

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately): avg_out=0, min_out=0, max_out=0, avg_valid=0, sample_cnt=0, accumulator=0, discard counter=0, running min=all ones, running max=0, state=DISCARD (ACCUM if DISCARD=0).
- Accumulator width: DATA_W+LOG2_N bits. It never overflows; full scale gives (2^DATA_W-1)*2^LOG2_N.
- State DISCARD: each sample_en increments the discard counter; data_in is ignored. On the DISCARD-th pulse, go to ACCUM. No outputs change.
- State ACCUM, on sample_en:
  - acc += data_in; sample_cnt increments.
  - running min/max update with data_in.
- Block completion: sample_en while sample_cnt = 2^LOG2_N-1. On that same edge:
  - avg_out <= (acc + data_in) >> LOG2_N, truncating.
  - min_out and max_out receive the running values including this sample.
  - avg_valid <= 1.
  - acc, sample_cnt, running min/max reinitialise. State stays ACCUM.
- Latency: avg_valid is high for exactly the one cycle after the edge that accepts the final sample of the block.
- Block boundaries: back-to-back blocks have no gap. A sample_en on the cycle avg_valid is high counts as sample 0 of the next block.
- sample_en=0: data_in is don't-care. State, accumulator and running min/max hold; avg_valid returns to 0.
- clear=1:
  - acc, sample_cnt, discard counter and running min/max reinitialise; state goes to DISCARD (ACCUM if DISCARD=0).
  - avg_out, min_out and max_out keep their last published values; avg_valid=0.
  - clear has priority over sample_en in the same cycle; that sample is dropped.
  - clear on the completion cycle: no publish, block discarded.
- Illegal/unused state encodings recover to DISCARD on the next edge.

Decomposition:
- Shared package lab05_pkg:
  - DATA_W default constant.
  - State enum avg_state_t {DISCARD, ACCUM}.
  - Helper function for accumulator width (DATA_W+LOG2_N).
- One natural sub-module, minmax_tracker: holds the running min/max, with init, update and sample ports. It is instantiated once.
- The FSM, counters and accumulator stay in the top.

Test Plan (LOG2_N=2, DISCARD=2 unless stated):
- Reset → 2 discard samples of 0xFFF, then samples 100,200,300,400 → avg_out=250, min_out=100, max_out=400; avg_valid high exactly one cycle after the 4th sample edge; discard samples have no effect.
- Four samples of 0xFFF → accumulator 0x3FFC, avg_out=0xFFF, min_out=max_out=0xFFF; no overflow.
- Samples 1,1,1,2 → avg_out=1 (5>>2, truncation); next block 0,0,0,0 back-to-back with no gap → avg_out=0, second avg_valid four sample edges later.
- Samples interleaved with 3 idle cycles each; data_in driven 0xABC while sample_en=0 → result identical to the gapless case; 0xABC never affects avg/min/max.
- After one full block (avg_out=250), 2 samples, then clear coincident with sample_en → sample_cnt=0, state DISCARD, avg_out still 250, no avg_valid; the next 2 samples are discarded, then a fresh 4-sample block publishes correctly.
- reset_n asserted between clock edges mid-block → all outputs 0 immediately, without waiting for a clock edge; after release, behaviour restarts from DISCARD.
